// File: rtl/sync_rr_arbiter_if.sv
// Handshake bundle between asynchronous requesters and the round-robin arbiter.
// master = requester/resource side, slave = arbiter side.
interface sync_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0] req_async;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic             timeout_pulse;

   modport master (
      output req_async, done,
      input  grant, grant_valid, grant_id, timeout_pulse
   );

   modport slave (
      input  req_async, done,
      output grant, grant_valid, grant_id, timeout_pulse
   );
endinterface

// File: rtl/sync_rr_arbiter.sv
// Round-robin arbiter for asynchronous request lines: synchronize, edge-detect, latch, grant.
// Define SYNC_RR_ARB_TIMEOUT_EN to build the MAX_HOLD grant timeout.
module sync_rr_arbiter #(
   parameter int N_REQ       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_HOLD    = 16,
   parameter int ID_W        = $clog2(N_REQ)
) (
   input  logic clk,
   input  logic reset_n,
   sync_rr_arbiter_if.slave bus
);

   if (N_REQ < 2 || N_REQ > 16 || SYNC_STAGES < 2 || MAX_HOLD < 2) begin : g_bad_param
      $error("sync_rr_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

   state_e                              state_q, state_d;
   logic [SYNC_STAGES-1:0][N_REQ-1:0]   sync_q, sync_d;
   logic [N_REQ-1:0]                    hist_q, hist_d;
   logic [N_REQ-1:0]                    pending_q, pending_d;
   logic [N_REQ-1:0]                    grant_q, grant_d;
   logic [ID_W-1:0]                     grant_id_q, grant_id_d;
   logic [ID_W-1:0]                     last_id_q, last_id_d;
   logic [N_REQ-1:0]                    rise, clr;
   logic [ID_W-1:0]                     hi_id, lo_id, sel_id;
   logic                                hi_found, lo_found;

`ifdef SYNC_RR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`endif

   always_comb begin
      sync_d[0] = bus.req_async;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      hist_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   // Lowest pending index above last_id wins; otherwise wrap to the lowest at or below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (pending_q[i]) begin
            if (ID_W'(i) > last_id_q) begin
               hi_found = 1'b1;
               hi_id    = ID_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_id    = ID_W'(i);
            end
         end
      end
      sel_id = hi_found ? hi_id : lo_id;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      clr        = '0;
`ifdef SYNC_RR_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (hi_found || lo_found) begin
               state_d    = GRANT;
               grant_d    = N_REQ'(1) << sel_id;
               grant_id_d = sel_id;
               clr        = N_REQ'(1) << sel_id;
`ifdef SYNC_RR_ARB_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         GRANT: begin
`ifdef SYNC_RR_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (bus.done) begin
               state_d    = RELEASE;
               grant_d    = '0;
               grant_id_d = '0;
               last_id_d  = grant_id_q;
`ifdef SYNC_RR_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(MAX_HOLD-1)) begin
               state_d    = RELEASE;
               grant_d    = '0;
               grant_id_d = '0;
               last_id_d  = grant_id_q;
               timeout_d  = 1'b1;
`endif
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A new edge landing on the clear cycle re-queues the request.
      pending_d = (pending_q & ~clr) | rise;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         hist_q     <= '0;
         pending_q  <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_id_q  <= ID_W'(N_REQ-1);
`ifdef SYNC_RR_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         pending_q  <= pending_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
`ifdef SYNC_RR_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.grant_id    = grant_id_q;
`ifdef SYNC_RR_ARB_TIMEOUT_EN
   assign bus.timeout_pulse = timeout_q;
`else
   assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Scoreboard bench for sync_rr_arbiter: directed stimulus pushes expected grants,
// a monitor checks id, one-hot pattern, length, inter-grant gap and timeout flag.
module tb_sync_rr_arbiter;
   localparam int N = 4;

   typedef struct {
      int id;
      int len;   // -1: do not check
      int to;    // -1: do not check
      int gap;   // -1: do not check
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   done_after = 0;
   int   rcnt = 0;
   exp_t exp_q[$];

   sync_rr_arbiter_if #(.N_REQ(N)) bus();

   sync_rr_arbiter #(.N_REQ(N), .SYNC_STAGES(2), .MAX_HOLD(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int id, input int len, input int to, input int gap);
      exp_t e;
      e.id = id; e.len = len; e.to = to; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_grant(input string name, input int budget);
      int n = 0;
      while (!bus.grant_valid && n < budget) begin
         cyc(1);
         n++;
      end
      chk({name, "_grant_seen"}, int'(bus.grant_valid), 1);
   endtask

   // Resource owner: pulse done on the done_after-th cycle of each grant (0 = never).
   always @(negedge clk) begin
      if (bus.grant_valid) begin
         rcnt++;
         bus.done = (done_after != 0 && rcnt == done_after);
      end else begin
         rcnt = 0;
         bus.done = 1'b0;
      end
   end

   // Monitor: compares each observed grant against the scoreboard head.
   bit in_grant = 0;
   int glen = 0;
   int idle_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (bus.grant_valid && !in_grant) begin
         in_grant = 1;
         glen = 1;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_grant: got grant %b expected none at %0t", bus.grant, $time);
         end else begin
            e = exp_q[0];
            chk("grant_id", int'(bus.grant_id), e.id);
            chk("grant_onehot", int'(bus.grant), 1 << e.id);
            if (e.gap >= 0) chk("gap", idle_cnt, e.gap);
         end
      end else if (bus.grant_valid) begin
         glen++;
      end else if (in_grant) begin
         in_grant = 0;
         idle_cnt = 1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.len >= 0) chk("grant_len", glen, e.len);
            if (e.to >= 0) chk("timeout_pulse", int'(bus.timeout_pulse), e.to);
         end
      end else begin
         idle_cnt++;
      end
   end

   initial begin
      bus.req_async = '0;
      bus.done = 1'b0;

      // Reset state
      cyc(2);
      chk("rst_grant", int'(bus.grant), 0);
      chk("rst_valid", int'(bus.grant_valid), 0);
      chk("rst_id", int'(bus.grant_id), 0);
      chk("rst_timeout", int'(bus.timeout_pulse), 0);
      reset_n = 1'b1;
      cyc(2);

      // Single request: grant visible after E0+3, done on first grant cycle
      done_after = 1;
      push(2, 1, 0, -1);
      bus.req_async[2] = 1'b1;
      cyc(3);
      chk("latency_early", int'(bus.grant_valid), 0);
      cyc(1);
      chk("latency_grant", int'(bus.grant), 4'b0100);
      chk("latency_id", int'(bus.grant_id), 2);
      cyc(1);
      chk("release_grant", int'(bus.grant_valid), 0);
      wait_empty("single", 20);
      bus.req_async = '0;
      cyc(4);

      // Fairness: all requests together, 0..3 each once
      do_reset();
      done_after = 3;
      push(0, 3, 0, -1);
      push(1, 3, 0, 2);
      push(2, 3, 0, 2);
      push(3, 3, 0, 2);
      bus.req_async = 4'b1111;
      wait_empty("fair", 60);
      cyc(10);
      bus.req_async = '0;
      cyc(4);

      // Rotation: 0 and 1 queued during grant of 3 -> wrap to 0, then 1
      do_reset();
      done_after = 6;
      push(3, 6, 0, -1);
      push(0, 6, 0, 2);
      push(1, 6, 0, 2);
      bus.req_async[3] = 1'b1;
      wait_grant("rot", 10);
      bus.req_async[1:0] = 2'b11;
      wait_empty("rot", 60);
      bus.req_async = '0;
      cyc(4);

      // Timeout / long hold
      do_reset();
`ifdef SYNC_RR_ARB_TIMEOUT_EN
      done_after = 0;
      push(1, 16, 1, -1);
      bus.req_async[1] = 1'b1;
      wait_empty("timeout", 40);
      cyc(1);
      chk("timeout_one_cycle", int'(bus.timeout_pulse), 0);
      bus.req_async = '0;
      cyc(4);
      // done on the timeout cycle wins
      done_after = 16;
      push(1, 16, 0, -1);
      bus.req_async[1] = 1'b1;
      wait_empty("done_at_limit", 40);
`else
      done_after = 120;
      push(1, 120, 0, -1);
      bus.req_async[1] = 1'b1;
      wait_empty("long_hold", 200);
`endif
      bus.req_async = '0;
      cyc(4);

      // Re-request during own grant; a held level gives no third grant
      do_reset();
      done_after = 6;
      push(0, 6, 0, -1);
      push(0, 6, 0, 2);
      bus.req_async[0] = 1'b1;
      wait_grant("rereq", 10);
      bus.req_async[0] = 1'b0;
      cyc(2);
      bus.req_async[0] = 1'b1;
      wait_empty("rereq", 40);
      cyc(20);
      chk("rereq_no_third", int'(bus.grant_valid), 0);
      bus.req_async = '0;
      cyc(4);

      // Asynchronous reset mid-grant
      do_reset();
      done_after = 0;
      push(3, -1, -1, -1);
      bus.req_async[3] = 1'b1;
      wait_grant("midrst", 10);
      bus.req_async[1:0] = 2'b11;
      cyc(4);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_grant", int'(bus.grant), 0);
      chk("midrst_valid", int'(bus.grant_valid), 0);
      chk("midrst_id", int'(bus.grant_id), 0);
      bus.req_async = '0;
      cyc(2);
      reset_n = 1'b1;
      cyc(20);
      chk("midrst_no_grant", int'(bus.grant_valid), 0);
      chk("midrst_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
